// File: rtl/regfile_pkg.sv
// Shared widths, requester identifiers and the write-request record used around
// the register-file write-back path.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 1 << ADDR_W;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry holding buffer for a pending register write, with a full flag and an
// age bit that marks it as the older of the two slots when both are occupied.
module wb_slot #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              drain,
  input  logic              age_in,
  input  logic              promote,
  input  logic [ADDR_W-1:0] load_reg,
  input  logic [DATA_W-1:0] load_data,
  output logic              full,
  output logic              age,
  output logic [ADDR_W-1:0] held_reg,
  output logic [DATA_W-1:0] held_data
);

  logic keep;

  // Writes to register 0 are accepted but never held.
  assign keep = (load_reg != '0);

  // NOTE: non-blocking assignments for every flop so all state samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full      <= 1'b0;
      age       <= 1'b0;
      held_reg  <= '0;
      held_data <= '0;
    end else if (capture) begin
      // Capture only happens when empty or draining, so it takes precedence.
      full      <= keep;
      age       <= keep & age_in;
      held_reg  <= load_reg;
      held_data <= load_data;
    end else if (drain) begin
      full <= 1'b0;
      age  <= 1'b0;
    end else if (promote && full) begin
      age <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single-write-port register file: two holding slots,
// round-robin / oldest-first grant, registered write port and a pending-write mask.
module regfile_wb_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREG   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              write_back_en,
  output logic [ADDR_W-1:0] write_back_reg,
  output logic [DATA_W-1:0] write_back,
  output logic [NREG-1:0]   pending
);

  import regfile_pkg::REQ_ALU;
  import regfile_pkg::REQ_MEM;

  logic [1:0]        full, age, grant, capture, age_in, promote;
  logic [ADDR_W-1:0] slot_reg  [2];
  logic [DATA_W-1:0] slot_data [2];
  logic              rr, rr_flip;

  assign req0_ready       = ~full[REQ_ALU] | grant[REQ_ALU];
  assign req1_ready       = ~full[REQ_MEM] | grant[REQ_MEM];
  assign capture[REQ_ALU] = req0_valid & req0_ready;
  assign capture[REQ_MEM] = req1_valid & req1_ready;

  // A new capture is younger than anything the other slot keeps; on a shared
  // capture edge the memory slot counts as older. A lone survivor becomes oldest.
  assign age_in[REQ_ALU]  = ~((full[REQ_MEM] & ~grant[REQ_MEM]) |
                              (capture[REQ_MEM] & (req1_reg != '0)));
  assign age_in[REQ_MEM]  = ~(full[REQ_ALU] & ~grant[REQ_ALU]);
  assign promote[REQ_ALU] = ~full[REQ_MEM] | grant[REQ_MEM];
  assign promote[REQ_MEM] = ~full[REQ_ALU] | grant[REQ_ALU];

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_alu (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture[REQ_ALU]),
    .drain    (grant[REQ_ALU]),
    .age_in   (age_in[REQ_ALU]),
    .promote  (promote[REQ_ALU]),
    .load_reg (req0_reg),
    .load_data(req0_data),
    .full     (full[REQ_ALU]),
    .age      (age[REQ_ALU]),
    .held_reg (slot_reg[REQ_ALU]),
    .held_data(slot_data[REQ_ALU])
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_mem (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture[REQ_MEM]),
    .drain    (grant[REQ_MEM]),
    .age_in   (age_in[REQ_MEM]),
    .promote  (promote[REQ_MEM]),
    .load_reg (req1_reg),
    .load_data(req1_data),
    .full     (full[REQ_MEM]),
    .age      (age[REQ_MEM]),
    .held_reg (slot_reg[REQ_MEM]),
    .held_data(slot_data[REQ_MEM])
  );

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    grant   = '0;
    rr_flip = 1'b0;
    if (full[REQ_ALU] && full[REQ_MEM]) begin
      if (slot_reg[REQ_ALU] == slot_reg[REQ_MEM]) begin
        // Same destination: program order wins and the pointer is left alone.
        grant[age[REQ_MEM] ? REQ_MEM : REQ_ALU] = 1'b1;
      end else begin
        grant[rr ? REQ_MEM : REQ_ALU] = 1'b1;
        rr_flip = 1'b1;
      end
    end else if (full[REQ_ALU]) begin
      grant[REQ_ALU] = 1'b1;
    end else if (full[REQ_MEM]) begin
      grant[REQ_MEM] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr             <= 1'b0;
      write_back_en  <= 1'b0;
      write_back_reg <= '0;
      write_back     <= '0;
    end else begin
      if (rr_flip) rr <= ~rr;
      write_back_en <= |grant;
      if (grant[REQ_ALU]) begin
        write_back_reg <= slot_reg[REQ_ALU];
        write_back     <= slot_data[REQ_ALU];
      end else if (grant[REQ_MEM]) begin
        write_back_reg <= slot_reg[REQ_MEM];
        write_back     <= slot_data[REQ_MEM];
      end
    end
  end

  always_comb begin
    pending = '0;
    if (full[REQ_ALU]) pending[slot_reg[REQ_ALU]] = 1'b1;
    if (full[REQ_MEM]) pending[slot_reg[REQ_MEM]] = 1'b1;
    if (write_back_en) pending[write_back_reg] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a transaction-level model predicts grants
// into a queue, and a separate monitor pops and compares every write-back pulse.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int AW = ADDR_W;
  localparam int DW = DATA_W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_reg = '0, req1_reg = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          write_back_en;
  logic [AW-1:0] write_back_reg;
  logic [DW-1:0] write_back;
  logic [NREG-1:0] pending;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_reg      (req0_reg),
    .req0_data     (req0_data),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_reg      (req1_reg),
    .req1_data     (req1_data),
    .write_back_en (write_back_en),
    .write_back_reg(write_back_reg),
    .write_back    (write_back),
    .pending       (pending)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: each slot remembers the program-order sequence number of its write.
  bit            m_full [2];
  logic [AW-1:0] m_reg  [2];
  logic [DW-1:0] m_data [2];
  int unsigned   m_seq  [2];
  bit            m_rr;
  bit            m_wb_en;
  logic [AW-1:0] m_wb_reg;
  int unsigned   seq_cnt = 0;
  wb_req_t       sb [$];
  logic [DW-1:0] dut_rf  [NREG];
  logic [DW-1:0] prog_rf [NREG];
  int            p3_cycles = 0;

  function automatic int model_grant();
    if (m_full[0] && m_full[1]) begin
      if (m_reg[0] == m_reg[1]) return (m_seq[1] < m_seq[0]) ? 1 : 0;
      return m_rr ? 1 : 0;
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_rr = 0; m_wb_en = 0; m_wb_reg = '0;
    sb.delete();
  endtask

  task automatic cycle(input bit v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                       input bit v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1);
    int            g;
    bit            rdy0, rdy1;
    logic [NREG-1:0] exp_pend;
    wb_req_t       t;
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    @(negedge clk);
    g    = model_grant();
    rdy0 = !m_full[0] || g == 0;
    rdy1 = !m_full[1] || g == 1;
    check("ready0", 64'(req0_ready), 64'(rdy0));
    check("ready1", 64'(req1_ready), 64'(rdy1));
    exp_pend = '0;
    if (m_full[0]) exp_pend[m_reg[0]] = 1'b1;
    if (m_full[1]) exp_pend[m_reg[1]] = 1'b1;
    if (m_wb_en)   exp_pend[m_wb_reg] = 1'b1;
    exp_pend[0] = 1'b0;
    check("pending", 64'(pending), 64'(exp_pend));
    if (pending[3]) p3_cycles++;
    if (m_full[0] && m_full[1] && m_reg[0] != m_reg[1]) m_rr = !m_rr;
    m_wb_en = (g >= 0);
    if (g >= 0) begin
      t.rd = m_reg[g]; t.data = m_data[g];
      sb.push_back(t);
      m_wb_reg = m_reg[g];
      m_full[g] = 0;
    end
    // Same-edge captures: the memory requester is earlier in program order.
    if (v1 && rdy1 && r1 != '0) begin
      m_full[1] = 1; m_reg[1] = r1; m_data[1] = d1; m_seq[1] = seq_cnt++;
      prog_rf[r1] = d1;
    end
    if (v0 && rdy0 && r0 != '0) begin
      m_full[0] = 1; m_reg[0] = r0; m_data[0] = d0; m_seq[0] = seq_cnt++;
      prog_rf[r0] = d0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0);
  endtask

  wb_req_t mon_exp;
  always @(negedge clk) begin
    if (write_back_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL wb_unexpected: got write reg %0d data 0x%0h, expected no write",
                 write_back_reg, write_back);
      end else begin
        mon_exp = sb.pop_front();
        check("wb_reg", 64'(write_back_reg), 64'(mon_exp.rd));
        check("wb_data", 64'(write_back), 64'(mon_exp.data));
      end
      dut_rf[write_back_reg] = write_back;
    end
  end

  logic [DW-1:0] snap [NREG];

  initial begin
    for (int i = 0; i < NREG; i++) begin dut_rf[i] = '0; prog_rf[i] = '0; end
    model_reset();

    // Reset held with random requests.
    repeat (6) begin
      @(posedge clk); #1;
      req0_valid = 1'($urandom); req0_reg = AW'($urandom); req0_data = $urandom;
      req1_valid = 1'($urandom); req1_reg = AW'($urandom); req1_data = $urandom;
      @(negedge clk);
      check("rst_wb_en", 64'(write_back_en), 64'd0);
      check("rst_pending", 64'(pending), 64'd0);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    rst = 1'b1;
    #1;
    check("rel_wb_en", 64'(write_back_en), 64'd0);
    check("rel_wb_reg", 64'(write_back_reg), 64'd0);
    check("rel_wb_data", 64'(write_back), 64'd0);
    check("rel_pending", 64'(pending), 64'd0);
    check("rel_ready0", 64'(req0_ready), 64'd1);
    check("rel_ready1", 64'(req1_ready), 64'd1);

    // Contention: alternating 5, 6 starting with 5.
    for (int i = 0; i < 8; i++) cycle(1, AW'(5), DW'('hA), 1, AW'(6), DW'('hB));
    idle(4);

    // Same-register ordering, captured on the same edge, then req0 first.
    cycle(1, AW'(7), DW'('h11), 1, AW'(7), DW'('h22));
    idle(4);
    check("r7_same_edge", 64'(dut_rf[7]), 64'h11);
    cycle(1, AW'(7), DW'('h22), 0, '0, '0);
    cycle(0, '0, '0, 1, AW'(7), DW'('h11));
    cycle(1, AW'(7), DW'('h33), 0, '0, '0);
    idle(4);
    check("r7_staggered", 64'(dut_rf[7]), 64'h33);

    // Register 0 drop, then a lone write to reg 3.
    p3_cycles = 0;
    cycle(0, '0, '0, 1, AW'(0), DW'('h55));
    cycle(0, '0, '0, 1, AW'(3), DW'('h33));
    idle(4);
    check("pend3_cycles", 64'(p3_cycles), 64'd2);
    check("r0_untouched", 64'(dut_rf[0]), 64'd0);

    // Back-to-back stream from requester 0.
    for (int r = 1; r < NREG; r++) cycle(1, AW'(r), DW'(r), 0, '0, '0);
    idle(4);

    // Random traffic on a small register window to force same-register conflicts.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), AW'($urandom_range(0, 7)), $urandom,
            1'($urandom), AW'($urandom_range(0, 7)), $urandom);
    idle(4);
    check("sb_drained", 64'(sb.size()), 64'd0);
    for (int r = 1; r < NREG; r++) check($sformatf("rf_r%0d", r), 64'(dut_rf[r]), 64'(prog_rf[r]));

    // Reset with both slots full and the output stage active.
    cycle(1, AW'(9), DW'('h99), 1, AW'(10), DW'('hAA));
    cycle(1, AW'(11), DW'('hBB), 1, AW'(12), DW'('hCC));
    for (int r = 0; r < NREG; r++) snap[r] = dut_rf[r];
    check("pre_rst_wb_en", 64'(write_back_en), 64'd1);
    req0_valid = 0; req1_valid = 0;
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_wb_en", 64'(write_back_en), 64'd0);
    check("mid_rst_pending", 64'(pending), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(5);
    for (int r = 9; r <= 12; r++) check($sformatf("post_rst_r%0d", r), 64'(dut_rf[r]), 64'(snap[r]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scheduler for the CPU's single-write-port RegisterFile. It accepts result writes from two producers through valid/ready handshakes: requester 0 is the ALU/execute result, requester 1 is the memory-load or multi-cycle unit result. Each requester gets a one-entry holding slot. Each cycle the arbiter grants at most one slot and drives the RegisterFile `write_back_en` / `write_back_reg` / `write_back` inputs from registered outputs. It also exports a pending-write mask that the issue stage uses to stall.

## Interface
- `DATA_W`, default 32: width of write data.
- `ADDR_W`, default 5: register index width.
- `NREG`, default 32: number of architectural registers; `NREG = 2**ADDR_W`.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low (0 = reset asserted).
- `req0_valid`  in  1  requester 0 offers a write.
- `req0_ready`  out  1  requester 0 write accepted this cycle if valid.
- `req0_reg`  in  ADDR_W  requester 0 destination register.
- `req0_data`  in  DATA_W  requester 0 write data.
- `req1_valid`, `req1_ready`, `req1_reg`, `req1_data`: same as requester 0, for requester 1.
- `write_back_en`  out  1  to RegisterFile; registered.
- `write_back_reg`  out  ADDR_W  to RegisterFile; registered.
- `write_back`  out  DATA_W  to RegisterFile; registered.
- `pending`  out  NREG  bit r = 1 when a write to register r is held in a slot or on the output stage.

## Operation
- **Handshake:** a transfer occurs on an edge where `reqN_valid & reqN_ready`; the slot captures reg and data. `reqN_ready = ~slotN_full | grantN`, so a slot can be refilled in the same cycle it drains. `reqN_ready` does not depend on `reqN_valid`.
- **Register 0:** a transfer whose reg is 0 is accepted but dropped. The slot stays or becomes empty, the write never reaches the outputs, and `pending[0]` is always 0.
- **Grant (combinational on slot state):**
  - Only one slot full: that slot is granted.
  - Both full, different regs: grant goes to the slot selected by round-robin pointer `rr`. `rr` toggles to the other requester after every contested grant.
  - Both full, same reg: the older slot wins regardless of `rr`, and `rr` is unchanged.
  - Age: each slot has an age bit set at capture. If both slots capture on the same edge, slot 1 is older, because the memory stage is ahead in program order.
- **Output stage:** on a grant, the granted slot's reg/data load into `write_back_reg` / `write_back` and `write_back_en` is 1 for the next cycle. With no grant, `write_back_en` is 0 and reg/data hold their previous values.
- **Pending mask:** OR of one-hot(slot0.reg) if full, one-hot(slot1.reg) if full, and one-hot(`write_back_reg`) if `write_back_en`. Bit 0 is forced to 0.
- **Reset values:** slots empty, age bits 0, `rr` = 0 (requester 0 wins first contest), `write_back_en` = 0, `write_back_reg` = 0, `write_back` = 0, `pending` = 0, both readies 1 (as soon as `rst` deasserts).
- **Reset mid-operation:** all held writes are discarded, with no partial write-back. An output asserted before reset drops asynchronously.

## Timing
- **Latency:** accepted on edge t → slot full after t → output loaded on edge t+1 (if granted) → RegisterFile writes on edge t+2.
- **Uncontested throughput:** one write per cycle per requester; the ready stays high continuously.
- **Contested throughput:** one write per cycle total, alternating between requesters. Each requester sees ready low every other cycle.
- **Ordering:** the same-register older-first rule keeps the final RegisterFile value in program order.
- **`pending` timing:** purely combinational from registered state. It rises the cycle after capture and falls the cycle after the RegisterFile write edge.

## Structure
- **Shared package `regfile_pkg`:** `DATA_W`, `ADDR_W`, `NREG`, requester IDs `REQ_ALU = 0` and `REQ_MEM = 1`, and a packed `wb_req_t` struct {reg, data}.
- **Sub-module `wb_slot`:** one-entry holding buffer with full flag, age bit, capture/drain inputs and a reg-0 drop. It is instantiated twice. Arbitration, the output stage and the pending mask live in the top level.

## Test plan
- **Reset:** hold `rst` = 0 with random requests, then release → all outputs 0, both ready = 1, no `write_back_en` pulse.
- **Single requester stream:** req0 sends regs 1..31 with data = reg, back-to-back → `write_back_en` high 31 consecutive cycles starting 1 cycle after the first accept, values 1..31 in order.
- **Contention:** both valid every cycle, req0 sends reg 5/data 0xA, req1 sends reg 6/data 0xB → outputs alternate 5, 6, 5, 6 starting with 5; readies toggle.
- **Same-register ordering:** both slots filled on the same edge with reg 7, data0 = 0x11, data1 = 0x22 → write 0x22 first, then 0x11; RegisterFile r7 ends as 0x11. Repeat with req0 captured one cycle earlier → 0x11 first.
- **Register 0 drop and pending:** req1 writes reg 0 then reg 3 → no write to 0; `pending[3]` = 1 for exactly 2 cycles; `pending[0]` never 1.
- **Reset mid-operation:** both slots full plus an active output, assert `rst` → `write_back_en` falls immediately, `pending` = 0, and nothing is written after release.
